// File: rtl/ysyx_24110006_axi_sram.sv
// Single-beat AXI4 slave backed by a word-organised SRAM with a fixed response latency.
// One transaction in flight; reads take priority over writes in the idle state.
module ysyx_24110006_axi_sram #(
    parameter int unsigned ADDR_W  = 10,
    parameter logic [31:0] BASE    = 32'h8000_0000,
    parameter int unsigned LATENCY = 2
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic [31:0] i_axi_araddr,
    input  logic        i_axi_arvalid,
    input  logic [3:0]  i_axi_arid,
    input  logic [7:0]  i_axi_arlen,
    input  logic [2:0]  i_axi_arsize,
    input  logic [1:0]  i_axi_arburst,
    output logic        o_axi_arready,
    output logic [31:0] o_axi_rdata,
    output logic        o_axi_rvalid,
    output logic [1:0]  o_axi_rresp,
    output logic        o_axi_rlast,
    output logic [3:0]  o_axi_rid,
    input  logic        i_axi_rready,
    input  logic [31:0] i_axi_awaddr,
    input  logic        i_axi_awvalid,
    input  logic [3:0]  i_axi_awid,
    input  logic [7:0]  i_axi_awlen,
    input  logic [2:0]  i_axi_awsize,
    input  logic [1:0]  i_axi_awburst,
    output logic        o_axi_awready,
    input  logic [31:0] i_axi_wdata,
    input  logic [3:0]  i_axi_wstrb,
    input  logic        i_axi_wvalid,
    input  logic        i_axi_wlast,
    output logic        o_axi_wready,
    output logic [1:0]  o_axi_bresp,
    output logic        o_axi_bvalid,
    output logic [3:0]  o_axi_bid,
    input  logic        i_axi_bready
);

    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY == 0) ? '0 : CNT_W'(LATENCY - 1);

    typedef enum logic [2:0] {StIdle, StRwait, StRresp, StWwait, StBresp} state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [31:0]       r_rdata;
    logic [1:0]        r_rresp;
    logic [3:0]        r_rid;
    logic [1:0]        r_bresp;
    logic [3:0]        r_bid;
    logic [31:0]       r_mem [2**ADDR_W];

    logic              w_ar_hs;
    logic              w_aw_hs;
    logic [31:0]       w_ar_off;
    logic [31:0]       w_aw_off;
    logic [ADDR_W-1:0] w_ar_idx;
    logic [ADDR_W-1:0] w_aw_idx;
    logic [1:0]        w_ar_resp;
    logic [1:0]        w_aw_resp;
    logic              w_unused;

    assign o_axi_arready = (r_state == StIdle) && !i_reset;
    assign o_axi_awready = (r_state == StIdle) && !i_reset && i_axi_awvalid && i_axi_wvalid
                           && !i_axi_arvalid;
    assign o_axi_wready  = o_axi_awready;
    assign w_ar_hs       = o_axi_arready && i_axi_arvalid;
    assign w_aw_hs       = o_axi_awready;

    // Offsets wrap below BASE, so a single upper-bits test covers both range ends.
    assign w_ar_off  = i_axi_araddr - BASE;
    assign w_aw_off  = i_axi_awaddr - BASE;
    assign w_ar_idx  = w_ar_off[ADDR_W+1:2];
    assign w_aw_idx  = w_aw_off[ADDR_W+1:2];
    assign w_ar_resp = (w_ar_off[31:ADDR_W+2] != '0) ? 2'b11 :
                       (i_axi_arlen != 8'd0)         ? 2'b10 : 2'b00;
    assign w_aw_resp = (w_aw_off[31:ADDR_W+2] != '0)          ? 2'b11 :
                       (i_axi_awlen != 8'd0 || !i_axi_wlast)  ? 2'b10 : 2'b00;

    assign w_unused = ^{i_axi_arsize, i_axi_arburst, i_axi_awsize, i_axi_awburst,
                        w_ar_off[1:0], w_aw_off[1:0]};

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_ar_hs) begin
                    w_state_next = (LATENCY == 0) ? StRresp : StRwait;
                end else if (w_aw_hs) begin
                    w_state_next = (LATENCY == 0) ? StBresp : StWwait;
                end
            end
            StRwait: if (r_cnt == '0) w_state_next = StRresp;
            StRresp: if (i_axi_rready) w_state_next = StIdle;
            StWwait: if (r_cnt == '0) w_state_next = StBresp;
            StBresp: if (i_axi_bready) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Read data is fetched at acceptance; no write can intervene while a read is in flight.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_cnt   <= '0;
            r_rdata <= '0;
            r_rresp <= 2'b00;
            r_rid   <= '0;
            r_bresp <= 2'b00;
            r_bid   <= '0;
        end else if (w_ar_hs) begin
            r_cnt   <= CNT_LOAD;
            r_rid   <= i_axi_arid;
            r_rresp <= w_ar_resp;
            r_rdata <= (w_ar_resp == 2'b00) ? r_mem[w_ar_idx] : '0;
        end else if (w_aw_hs) begin
            r_cnt   <= CNT_LOAD;
            r_bid   <= i_axi_awid;
            r_bresp <= w_aw_resp;
        end else if ((r_state == StRwait || r_state == StWwait) && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (w_aw_hs && w_aw_resp == 2'b00) begin
            for (int k = 0; k < 4; k++) begin
                if (i_axi_wstrb[k]) begin
                    r_mem[w_aw_idx][8*k +: 8] <= i_axi_wdata[8*k +: 8];
                end
            end
        end
    end

    assign o_axi_rvalid = (r_state == StRresp);
    assign o_axi_rlast  = (r_state == StRresp);
    assign o_axi_rdata  = r_rdata;
    assign o_axi_rresp  = r_rresp;
    assign o_axi_rid    = r_rid;
    assign o_axi_bvalid = (r_state == StBresp);
    assign o_axi_bresp  = r_bresp;
    assign o_axi_bid    = r_bid;

endmodule
